// File: rtl/dual_port_ram_modport.sv
// dual_port_ram_modport
//   True dual-port synchronous RAM shared between two masters. Both ports
//   can read and write on the same clock. Read data is registered, so it
//   appears one cycle after the address. Reads are read-first.
//   On a same-address write collision, port A's data is stored and
//   o_conflict flags the collision on the next cycle. After reset, an
//   internal sequencer writes zero to every word. Port traffic is ignored
//   until o_ready rises.
//
// Ports
//   i_clk, i_rst         clock (rising edge), async active-high reset
//   o_ready              array initialisation complete, ports accepted
//   o_conflict           last accepted cycle had an A/B same-address write
//   a_we/a_addr/a_din    port A write enable, address, write data
//   a_dout               port A registered read data
//   b_we/b_addr/b_din    port B write enable, address, write data
//   b_dout               port B registered read data
module dual_port_ram_modport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_ready,
  output logic                  o_conflict,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_last;
  logic                  ready;

  logic                  a_in_range, b_in_range, same_addr;
  logic                  a_wr, b_wr;

  // The init sequencer shares the write path with port A.
  // Both are never active in the same cycle.
  logic                  wr0_en;
  logic [ADDR_WIDTH-1:0] wr0_addr;
  logic [DATA_WIDTH-1:0] wr0_data;

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign init_last = (init_cnt_q == ADDR_WIDTH'(MEM_DEPTH - 1));
  assign ready     = (state_q == ST_READY);

  // Widen by one bit so the comparison also works when MEM_DEPTH == 2^ADDR_WIDTH.
  assign a_in_range = ({1'b0, a_addr} < (ADDR_WIDTH + 1)'(MEM_DEPTH));
  assign b_in_range = ({1'b0, b_addr} < (ADDR_WIDTH + 1)'(MEM_DEPTH));
  assign same_addr  = (a_addr == b_addr);

  // Port A wins a same-address collision. B's write is suppressed even if
  // the shared address is out of range, so neither write lands.
  assign a_wr = ready & a_we & a_in_range;
  assign b_wr = ready & b_we & b_in_range & ~(a_we & same_addr);

  always_comb begin
    wr0_en   = a_wr;
    wr0_addr = a_addr;
    wr0_data = a_din;
    if (state_q == ST_INIT) begin
      wr0_en   = 1'b1;
      wr0_addr = init_cnt_q;
      wr0_data = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_last) state_d = ST_READY;
      end
      ST_READY: ;
      default: state_d = ST_INIT;
    endcase
  end

  // Array storage: no reset, contents are cleared by the init sequencer.
  always_ff @(posedge i_clk) begin
    if (wr0_en) mem[wr0_addr] <= wr0_data;
    if (b_wr)   mem[b_addr]   <= b_din;
  end

  // Control and registered read data. Reads sample the array before this
  // edge's writes land, which gives read-first on both ports.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      o_ready    <= 1'b0;
      o_conflict <= 1'b0;
      a_dout     <= '0;
      b_dout     <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      o_ready    <= (state_d == ST_READY);
      if (ready) begin
        a_dout     <= a_in_range ? mem[a_addr] : '0;
        b_dout     <= b_in_range ? mem[b_addr] : '0;
        o_conflict <= a_we & b_we & same_addr;
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram_modport.sv
// tb_dual_port_ram_modport
//   Directed bench for dual_port_ram_modport at its default geometry
//   (32-bit words, 1024 entries).
module tb_dual_port_ram_modport;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          o_ready, o_conflict;
  logic          a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din, a_dout, b_dout;

  int checks = 0;
  int errors = 0;
  int n;
  logic dirty;

  dual_port_ram_modport dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_ready(o_ready), .o_conflict(o_conflict),
    .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout),
    .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts the cycles until o_ready rises and watches that outputs stay quiet.
  task automatic wait_init(output int cycles, output logic seen_activity);
    cycles = 0;
    seen_activity = 1'b0;
    while (!o_ready && cycles < 2000) begin
      tick();
      cycles++;
      if (a_dout !== '0 || b_dout !== '0 || o_conflict !== 1'b0) seen_activity = 1'b1;
    end
  endtask

  initial begin
    i_rst = 1'b1;
    a_we = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0;
    a_din = '0;  b_din = '0;
    tick(); tick();
    check("rst_a_dout", a_dout, 32'h0);
    check("rst_b_dout", b_dout, 32'h0);
    check("rst_ready", {31'b0, o_ready}, 32'h0);
    check("rst_conflict", {31'b0, o_conflict}, 32'h0);

    // Colliding writes during INIT must be dropped.
    a_we = 1'b1; a_addr = 10'h030; a_din = 32'hFFFF_FFFF;
    b_we = 1'b1; b_addr = 10'h030; b_din = 32'hEEEE_EEEE;
    i_rst = 1'b0;
    wait_init(n, dirty);
    check("init_cycles", n, 32'd1024);
    check("init_quiet", {31'b0, dirty}, 32'h0);
    a_we = 1'b0; b_we = 1'b0;

    a_addr = 10'd0; b_addr = 10'd5;
    tick();
    check("zero_rd0", a_dout, 32'h0);
    check("zero_rd5", b_dout, 32'h0);
    a_addr = 10'd1023; b_addr = 10'h030;
    tick();
    check("zero_rd1023", a_dout, 32'h0);
    check("init_wr_dropped", b_dout, 32'h0);

    // A writes, old value on A during the write, then B reads it back.
    a_we = 1'b1; a_addr = 10'h010; a_din = 32'hDEAD_BEEF;
    tick();
    check("a_rd_during_wr", a_dout, 32'h0);
    a_we = 1'b0; b_addr = 10'h010;
    tick();
    check("b_rd_after_a_wr", b_dout, 32'hDEAD_BEEF);

    // Same-address collision: A wins.
    a_we = 1'b1; a_addr = 10'h020; a_din = 32'h1111_1111;
    b_we = 1'b1; b_addr = 10'h020; b_din = 32'h2222_2222;
    tick();
    check("conflict_set", {31'b0, o_conflict}, 32'h1);
    a_we = 1'b0; b_we = 1'b0;
    tick();
    check("conflict_clr", {31'b0, o_conflict}, 32'h0);
    check("collide_a", a_dout, 32'h1111_1111);
    check("collide_b", b_dout, 32'h1111_1111);

    // Concurrent writes to different addresses.
    a_we = 1'b1; a_addr = 10'd3; a_din = 32'hAAAA_0001;
    b_we = 1'b1; b_addr = 10'd4; b_din = 32'hBBBB_0002;
    tick();
    check("diff_no_conflict", {31'b0, o_conflict}, 32'h0);
    a_we = 1'b0; b_we = 1'b0; a_addr = 10'd4; b_addr = 10'd3;
    tick();
    check("diff_rd4", a_dout, 32'hBBBB_0002);
    check("diff_rd3", b_dout, 32'hAAAA_0001);

    // Read-first, same port and cross port.
    a_we = 1'b1; a_addr = 10'd7; a_din = 32'h5;
    tick();
    a_din = 32'h9; b_addr = 10'd7;
    tick();
    check("rf_cross_b", b_dout, 32'h5);
    check("rf_same_a", a_dout, 32'h5);
    a_we = 1'b0;
    tick();
    check("rf_next_b", b_dout, 32'h9);
    check("rf_next_a", a_dout, 32'h9);

    // Mid-traffic reset.
    a_we = 1'b1; a_addr = 10'd1; a_din = 32'h1234_5678;
    tick();
    a_we = 1'b0; b_addr = 10'd1;
    tick();
    check("pre_rst_rd1", b_dout, 32'h1234_5678);
    a_we = 1'b1; a_addr = 10'd2; a_din = 32'hCAFE_F00D;
    #2;
    i_rst = 1'b1;
    #1;
    check("async_a_dout", a_dout, 32'h0);
    check("async_b_dout", b_dout, 32'h0);
    check("async_ready", {31'b0, o_ready}, 32'h0);
    tick();
    i_rst = 1'b0; a_we = 1'b0;
    wait_init(n, dirty);
    check("reinit_cycles", n, 32'd1024);
    a_addr = 10'd1; b_addr = 10'd2;
    tick();
    check("reinit_rd1", a_dout, 32'h0);
    check("reinit_rd2", b_dout, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
